packet_read_adapter: RTL and testbench
======================================

PACKET_READ_ADAPTER -- requirements
Module: packet_read_adapter

Interface
REQ-001 Parameter PACKET_BYTE_ADDR_WIDTH, 12: byte address width of the CPU packet read port.
REQ-002 Parameter PACKET_ADDR_WIDTH, PACKET_BYTE_ADDR_WIDTH-2: word address width of the packet buffer.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port rd_en, input, 1: single-cycle read strobe from the CPU core.
REQ-006 Port byte_addr, input, PACKET_BYTE_ADDR_WIDTH: packet byte address of the first byte to read.
REQ-007 Port transfer_sz, input, 2: read size; 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 Port packet_len, input, 32: current packet length in bytes; stable while busy.
REQ-009 Port mem_rd_en, output, 1: packet buffer read enable.
REQ-010 Port mem_addr, output, PACKET_ADDR_WIDTH: packet buffer word address.
REQ-011 Port mem_data, input, 32: buffer read data, valid exactly 1 cycle after mem_rd_en; byte 0 in bits 31:24 (network order).
REQ-012 Port packet_data, output, 32: zero-extended read result for the CPU core.
REQ-013 Port mem_ready, output, 1: one-cycle pulse; packet_data/oob valid.
REQ-014 Port oob, output, 1: qualifies mem_ready; read out of bounds or illegal size.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 The block SHALL use FSM states IDLE, ISSUE0, ISSUE1, CAPTURE, DONE.
REQ-017 In IDLE, rd_en=1 SHALL latch byte_addr and transfer_sz; rd_en SHALL be ignored in all other states.
REQ-018 size_bytes = 1/2/4 for transfer_sz 0/1/2; end = byte_addr + size_bytes, computed 33 bits wide with no wrap.
REQ-019 A request is out of bounds if transfer_sz=3, or end > packet_len, or end > 2^PACKET_BYTE_ADDR_WIDTH.
REQ-020 An out-of-bounds request SHALL go IDLE->DONE: no mem_rd_en, mem_ready=1 and oob=1 in cycle T+1 (T = rd_en cycle), packet_data=0.
REQ-021 An in-bounds request SHALL go IDLE->ISSUE0, which drives mem_rd_en=1 and mem_addr=byte_addr[MSBs:2] in T+1.
REQ-022 Span = (byte_addr[1:0] + size_bytes > 4). With span, ISSUE0->ISSUE1, which drives mem_rd_en=1 and mem_addr=word0+1 in T+2 and captures word0 data.
REQ-023 Without span, ISSUE0->CAPTURE.
REQ-024 CAPTURE SHALL capture the final word and register the result; CAPTURE->DONE.
REQ-025 Assembly: form {word0, word1 or 0}, shift left by 8*byte_addr[1:0], take the top size_bytes bytes, and right-justify them zero-extended.
REQ-026 DONE SHALL assert mem_ready=1 for exactly one cycle, then go to IDLE.
REQ-027 In-bounds latency, rd_en to mem_ready: 3 cycles without span (T+3), 4 cycles with span (T+4).
REQ-028 mem_rd_en SHALL be high only in ISSUE0/ISSUE1; mem_addr SHALL hold its last value otherwise.
REQ-029 packet_data and oob SHALL hold from mem_ready until the next mem_ready.
REQ-030 end == packet_len SHALL be in bounds; packet_len=0 SHALL make every read oob.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE and mem_rd_en, mem_addr, packet_data, mem_ready, oob, busy all to 0.
REQ-032 Reset mid-operation SHALL abort the request with no mem_ready.
REQ-033 The first request SHALL be accepted in the first cycle after rst deasserts.

Verification (buffer word0=0x11223344, word1=0x55667788, packet_len=8)
REQ-034 word @0 -> mem_rd_en addr 0 at T+1; mem_ready at T+3, packet_data=0x11223344, oob=0.
REQ-035 byte @5 -> one read of addr 1; packet_data=0x00000066 at T+3.
REQ-036 half @3 -> reads of addr 0 (T+1) then addr 1 (T+2); packet_data=0x00004455 at T+4.
REQ-037 word @4 -> 0x55667788, oob=0 (end==len); word @6 -> oob=1, data 0 at T+1, no mem_rd_en; transfer_sz=3 @0 -> oob=1 at T+1.
REQ-038 word @1 -> rst asserted at T+2 -> outputs 0 immediately, no mem_ready; new byte @0 after release -> 0x00000011.
REQ-039 rd_en pulsed at T+1 during busy -> ignored; exactly one mem_ready.

Source files
------------

// File: rtl/packet_read_adapter.sv
// Packet read adapter: turns a CPU byte/half/word read of the packet buffer
// into one or two word reads. It bounds-checks the request against the
// packet length and returns the bytes right-justified and zero-extended.
module packet_read_adapter #(
  parameter int unsigned PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int unsigned PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_addr,
  input  logic [1:0]                        transfer_sz,
  input  logic [31:0]                       packet_len,
  output logic                              mem_rd_en,
  output logic [PACKET_ADDR_WIDTH-1:0]      mem_addr,
  input  logic [31:0]                       mem_data,
  output logic [31:0]                       packet_data,
  output logic                              mem_ready,
  output logic                              oob,
  output logic                              busy
);

  localparam int unsigned BW = PACKET_BYTE_ADDR_WIDTH;
  localparam int unsigned AW = PACKET_ADDR_WIDTH;
  localparam int unsigned EW = 33;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE0  = 3'd1,
    ISSUE1  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_nx;

  // Request attributes latched on acceptance
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        span_q;
  logic [31:0] word0_q;

  // Decode of the incoming request
  logic [2:0]    req_size_c;
  logic [EW-1:0] req_end_c;
  logic [EW-1:0] addr_limit_c;
  logic          req_oob_c;
  logic          req_span_c;

  // Result assembly
  logic [63:0] pair_c;
  logic [63:0] shifted_c;
  logic [31:0] top_c;
  logic [5:0]  rsh_c;
  logic [31:0] result_c;

  // Request size in bytes; the illegal code is flagged separately
  always_comb begin
    req_size_c = 3'd4;
    case (transfer_sz)
      2'd0:    req_size_c = 3'd1;
      2'd1:    req_size_c = 3'd2;
      default: req_size_c = 3'd4;
    endcase
  end

  // Bounds and word-span checks, evaluated 33 bits wide so nothing wraps
  always_comb begin
    req_end_c    = EW'(byte_addr) + EW'(req_size_c);
    addr_limit_c = EW'(1) << BW;
    req_oob_c    = (transfer_sz == 2'd3)
                || (req_end_c > EW'(packet_len))
                || (req_end_c > addr_limit_c);
    req_span_c   = (3'(byte_addr[1:0]) + req_size_c) > 3'd4;
  end

  // Align {word0, word1-or-0}, keep the top size bytes, right-justify them
  always_comb begin
    pair_c    = span_q ? {word0_q, mem_data} : {mem_data, 32'h0};
    shifted_c = pair_c << {off_q, 3'b000};
    top_c     = shifted_c[63:32];
    rsh_c     = {3'd4 - size_q, 3'b000};
    result_c  = top_c >> rsh_c;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; rd_en only matters in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rd_en) state_nx = req_oob_c ? DONE : ISSUE0;
      ISSUE0:  state_nx = span_q ? ISSUE1 : CAPTURE;
      ISSUE1:  state_nx = CAPTURE;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch request attributes and the first word of a spanning read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= 2'd0;
      size_q  <= 3'd0;
      span_q  <= 1'b0;
      word0_q <= 32'h0;
    end else begin
      if (state == IDLE && rd_en) begin
        off_q  <= byte_addr[1:0];
        size_q <= req_size_c;
        span_q <= req_span_c;
      end
      if (state == ISSUE1) word0_q <= mem_data;
    end
  end

  // Buffer read port, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_rd_en <= (state_nx == ISSUE0) || (state_nx == ISSUE1);
      if (state == IDLE && state_nx == ISSUE0)
        mem_addr <= AW'(byte_addr[BW-1:2]);
      else if (state_nx == ISSUE1)
        mem_addr <= mem_addr + AW'(1);
    end
  end

  // CPU-side result, completion pulse and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet_data <= 32'h0;
      oob         <= 1'b0;
      mem_ready   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_ready <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
      if (state == IDLE && state_nx == DONE) begin
        packet_data <= 32'h0;
        oob         <= 1'b1;
      end else if (state == CAPTURE) begin
        packet_data <= result_c;
        oob         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packet_read_adapter.sv
// Testbench for packet_read_adapter: fixed vectors, mid-operation reset,
// busy-time strobes and randomized reads checked against a byte-level model.
module tb_packet_read_adapter;

  localparam int unsigned BW = 12;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic [BW-1:0] byte_addr = '0;
  logic [1:0]    transfer_sz = 2'd0;
  logic [31:0]   packet_len = 32'd0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data = 32'h0;
  logic [31:0]   packet_data;
  logic          mem_ready;
  logic          oob;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_b [4096];

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  sz;
    logic [31:0] len;
    logic [31:0] data;
    logic        oob;
  } vec_t;

  vec_t vecs [15];

  packet_read_adapter #(
    .PACKET_BYTE_ADDR_WIDTH(BW),
    .PACKET_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .byte_addr(byte_addr),
    .transfer_sz(transfer_sz),
    .packet_len(packet_len),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .packet_data(packet_data),
    .mem_ready(mem_ready),
    .oob(oob),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Buffer: data one cycle after a read, garbage otherwise
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_data <= {mem_b[4*int'(mem_addr)], mem_b[4*int'(mem_addr)+1],
                   mem_b[4*int'(mem_addr)+2], mem_b[4*int'(mem_addr)+3]};
    else
      mem_data <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Reference: bounds from byte arithmetic, data gathered byte by byte
  function automatic logic [32:0] model(input logic [11:0] a, input logic [1:0] sz,
                                        input logic [31:0] len);
    int unsigned size;
    logic [63:0] e;
    logic [31:0] d;
    size = 32'd1 << sz;
    e = 64'(a) + 64'(size);
    if (sz == 2'd3 || e > 64'(len) || e > 64'd4096) return {1'b1, 32'h0};
    d = 32'h0;
    for (int i = 0; i < int'(size); i++) d = (d << 8) | 32'(mem_b[int'(a) + i]);
    return {1'b0, d};
  endfunction

  // One read transaction observed for 7 cycles after the strobe
  task automatic do_read(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] len,
                         input logic [31:0] exp_d, input logic exp_o,
                         input bit pulse, input bit rel_rst, input string tag);
    int size;
    bit span;
    int lat;
    int rcnt, rk, rd_err, busy_err;
    logic [31:0] gd;
    logic go;
    logic exp_rd;
    logic [AW-1:0] w0;
    size = 1 << sz;
    span = !exp_o && ((int'(a[1:0]) + size) > 4);
    lat = exp_o ? 1 : (span ? 4 : 3);
    rcnt = 0; rk = 0; rd_err = 0; busy_err = 0; gd = '0; go = 1'b0;
    w0 = a[11:2];
    @(negedge clk);
    if (rel_rst) rst = 1'b0;
    byte_addr = a; transfer_sz = sz; packet_len = len; rd_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_rd = !exp_o && (k == 1 || (k == 2 && span));
      if (mem_rd_en !== exp_rd) rd_err++;
      else if (exp_rd && mem_addr !== ((k == 1) ? w0 : AW'(w0 + 1))) rd_err++;
      if (busy !== (k <= lat)) busy_err++;
      if (mem_ready === 1'b1) begin
        rcnt++;
        if (rcnt == 1) begin rk = k; gd = packet_data; go = oob; end
      end
      rd_en = (k == 1) ? pulse : 1'b0;
      byte_addr = 12'($urandom);
      transfer_sz = 2'($urandom);
    end
    chk({tag, ".ready_cnt"}, 64'(rcnt), 64'd1);
    chk({tag, ".latency"}, 64'(rk), 64'(lat));
    chk({tag, ".data"}, 64'(gd), 64'(exp_d));
    chk({tag, ".oob"}, 64'(go), 64'(exp_o));
    chk({tag, ".rd_seq_errs"}, 64'(rd_err), 64'd0);
    chk({tag, ".busy_errs"}, 64'(busy_err), 64'd0);
    chk({tag, ".hold"}, {31'd0, oob, packet_data}, {31'd0, exp_o, exp_d});
  endtask

  initial begin
    logic [32:0] m;
    logic [11:0] ra;
    logic [1:0]  rs;
    logic [31:0] rl;
    int errs;

    for (int i = 0; i < 4096; i++) mem_b[i] = 8'($urandom);
    mem_b[0] = 8'h11; mem_b[1] = 8'h22; mem_b[2] = 8'h33; mem_b[3] = 8'h44;
    mem_b[4] = 8'h55; mem_b[5] = 8'h66; mem_b[6] = 8'h77; mem_b[7] = 8'h88;
    mem_b[4092] = 8'hDE; mem_b[4093] = 8'hAD; mem_b[4094] = 8'hBE; mem_b[4095] = 8'hEF;

    vecs[0]  = '{12'h000, 2'd2, 32'd8,    32'h11223344, 1'b0};
    vecs[1]  = '{12'h005, 2'd0, 32'd8,    32'h00000066, 1'b0};
    vecs[2]  = '{12'h003, 2'd1, 32'd8,    32'h00004455, 1'b0};
    vecs[3]  = '{12'h004, 2'd2, 32'd8,    32'h55667788, 1'b0};
    vecs[4]  = '{12'h006, 2'd2, 32'd8,    32'h00000000, 1'b1};
    vecs[5]  = '{12'h000, 2'd3, 32'd8,    32'h00000000, 1'b1};
    vecs[6]  = '{12'h000, 2'd0, 32'd0,    32'h00000000, 1'b1};
    vecs[7]  = '{12'h007, 2'd0, 32'd8,    32'h00000088, 1'b0};
    vecs[8]  = '{12'h007, 2'd1, 32'd8,    32'h00000000, 1'b1};
    vecs[9]  = '{12'h002, 2'd2, 32'd8,    32'h33445566, 1'b0};
    vecs[10] = '{12'h001, 2'd1, 32'd8,    32'h00002233, 1'b0};
    vecs[11] = '{12'hFFC, 2'd2, 32'd4096, 32'hDEADBEEF, 1'b0};
    vecs[12] = '{12'hFFE, 2'd2, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[13] = '{12'hFFF, 2'd0, 32'd4096, 32'h000000EF, 1'b0};
    vecs[14] = '{12'h006, 2'd1, 32'd8,    32'h00007788, 1'b0};

    // Reset state while rst is held
    #1;
    chk("reset_state", {58'd0, mem_rd_en, 10'(mem_addr) != 10'd0, packet_data != 32'd0,
                        mem_ready, oob, busy}, 64'd0);
    @(negedge clk);

    // Fixed vectors; the first is issued in the cycle rst deasserts
    for (int i = 0; i < 15; i++)
      do_read(vecs[i].addr, vecs[i].sz, vecs[i].len, vecs[i].data, vecs[i].oob,
              1'b0, (i == 0), $sformatf("vec%0d", i));

    // Strobes during busy must be ignored
    do_read(12'h003, 2'd1, 32'd8, 32'h00004455, 1'b0, 1'b1, 1'b0, "busy_strobe_span");
    do_read(12'h006, 2'd2, 32'd8, 32'h00000000, 1'b1, 1'b1, 1'b0, "busy_strobe_oob");

    // Reset in the middle of a spanning word read
    @(negedge clk);
    byte_addr = 12'h001; transfer_sz = 2'd2; packet_len = 32'd8; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_reset_outputs", {58'd0, mem_rd_en, 10'(mem_addr) != 10'd0,
                                packet_data != 32'd0, mem_ready, oob, busy}, 64'd0);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_ready !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("midop_reset_no_ready", 64'(errs), 64'd0);
    do_read(12'h000, 2'd0, 32'd8, 32'h00000011, 1'b0, 1'b0, 1'b1, "post_reset");

    // Randomized reads against the byte model, biased toward the length edge
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: rl = 32'($urandom_range(0, 4100));
        1: rl = 32'd4096;
        default: rl = 32'($urandom_range(0, 64));
      endcase
      if ($urandom_range(0, 1) == 0 && rl >= 32'd8)
        ra = 12'(rl - 32'($urandom_range(0, 6)));
      else
        ra = 12'($urandom);
      rs = 2'($urandom);
      m = model(ra, rs, rl);
      do_read(ra, rs, rl, m[31:0], m[32], bit'($urandom_range(0, 1)), 1'b0,
              $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
